// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if
//   Bundles the requester-side handshake and the memory-side bus of the
//   memory port arbiter.
//   Modports:
//     slave  - the arbiter: takes req/we/addr/wdata and mem_rdata,
//              drives gnt/done/rdata/busy and the mem_* command.
//     master - the requesters plus memory around the arbiter.
//   Signals:
//     req, we      N_REQ       level request / per-requester write enable
//     addr         N_REQ*AW    requester i at [i*AW +: AW]
//     wdata        N_REQ*DW    requester i at [i*DW +: DW]
//     gnt, done    N_REQ       one-hot grant / one-cycle completion pulse
//     rdata        DW          read data of the last completed read
//     busy         1           arbiter not idle
//     mem_en/we    1           memory enable / write enable
//     mem_addr     AW          latched memory address
//     mem_wdata    DW          latched memory write data
//     mem_rdata    DW          memory read data
interface mem_bus_arbiter_if #(
  parameter int N_REQ = 3,
  parameter int AW    = 8,
  parameter int DW    = 8
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    we;
  logic [N_REQ*AW-1:0] addr;
  logic [N_REQ*DW-1:0] wdata;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    done;
  logic [DW-1:0]       rdata;
  logic                busy;
  logic                mem_en;
  logic                mem_we;
  logic [AW-1:0]       mem_addr;
  logic [DW-1:0]       mem_wdata;
  logic [DW-1:0]       mem_rdata;

  modport slave (
    input  req, we, addr, wdata, mem_rdata,
    output gnt, done, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, we, addr, wdata, mem_rdata,
    input  gnt, done, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares the single processor memory port among N_REQ requesters
//   (0 = instruction fetch, 1 = load/store, 2 = debug/loader). In IDLE it
//   picks a winner, latches its command, holds the memory enabled for
//   MEM_LAT cycles, then pulses done for one cycle and returns to IDLE.
//   Ports:
//     clk    in  system clock, rising edge
//     reset  in  asynchronous, active-low reset
//     bus    mem_bus_arbiter_if.slave (requester handshake + memory bus)
//   Build option:
//     ARB_ROUND_ROBIN_EN - round-robin arbitration; otherwise fixed
//                          priority with the lowest index winning.
//
//   state  | meaning
//   IDLE   | waiting for any req; winner chosen and latched on the edge
//   ACCESS | mem_en held for MEM_LAT cycles, gnt to the winner
//   DONE   | one-cycle done pulse to the winner, gnt still high
module mem_bus_arbiter #(
  parameter int N_REQ   = 3,
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int MEM_LAT = 2
) (
  input logic             clk,
  input logic             reset,
  mem_bus_arbiter_if.slave bus
);
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [N_REQ-1:0] win_q;
  logic             we_q;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    wdata_q;
  logic [DW-1:0]    rdata_q;

  logic [IW-1:0]    pick;
  logic             sel_we;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_wdata;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IW-1:0]    ptr_q;
  int               dist;
  int               best;

  // Winner is the requester at the smallest rotational distance past ptr_q.
  always_comb begin
    pick = '0;
    best = N_REQ;
    dist = 0;
    for (int i = 0; i < N_REQ; i++) begin
      dist = (i + N_REQ - 1 - int'(ptr_q)) % N_REQ;
      if (bus.req[i] && dist < best) begin
        best = dist;
        pick = IW'(i);
      end
    end
  end
`else
  // Scan downwards so the lowest requesting index is the last assignment.
  always_comb begin
    pick = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) pick = IW'(i);
    end
  end
`endif

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick == IW'(i)) begin
        sel_we    = bus.we[i];
        sel_addr  = bus.addr[i*AW +: AW];
        sel_wdata = bus.wdata[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|bus.req) state_d = ACCESS;
      ACCESS:  if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      win_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q   <= IW'(N_REQ - 1);
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (|bus.req) begin
            win_q   <= ONE << pick;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            cnt_q   <= CW'(MEM_LAT - 1);
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q   <= pick;
`endif
          end
        end
        ACCESS: begin
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
          else if (!we_q)  rdata_q <= bus.mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode straight from the state register so an async reset
  // drops gnt/mem_en/mem_we immediately.
  assign bus.gnt       = (state_q == ACCESS || state_q == DONE) ? win_q : '0;
  assign bus.done      = (state_q == DONE) ? win_q : '0;
  assign bus.busy      = (state_q != IDLE);
  assign bus.mem_en    = (state_q == ACCESS);
  assign bus.mem_we    = (state_q == ACCESS) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.rdata     = rdata_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
  localparam int N   = 3;
  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int LAT = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.N_REQ(N), .AW(AW), .DW(DW)) bus();

  mem_bus_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int passed = 0;
  int total  = 0;

  // Transaction-level reference: m_t counts cycles since the grant
  // (0 = no transaction in flight).
  int             m_t;
  int             m_w;
  logic           m_we;
  logic [AW-1:0]  m_addr;
  logic [DW-1:0]  m_wdata;
  logic [DW-1:0]  m_rdata;
  int             m_ptr;
  int             m_pick;

  function automatic int pick_winner(input logic [N-1:0] r, input int ptr);
    logic [N-1:0] s;
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= N; k++) begin
      s = r >> ((ptr + k) % N);
      if (s[0]) return (ptr + k) % N;
    end
`else
    for (int i = 0; i < N; i++) begin
      s = r >> i;
      if (s[0] && ptr >= 0) return i;
    end
`endif
    return 0;
  endfunction

  function automatic logic bit_of(input logic [N-1:0] v, input int i);
    logic [N-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  function automatic logic [AW-1:0] field_of(input logic [N*AW-1:0] v, input int i);
    logic [N*AW-1:0] s;
    s = v >> (i * AW);
    return s[AW-1:0];
  endfunction

  always_comb m_pick = pick_winner(bus.req, m_ptr);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_t <= 0; m_w <= 0; m_we <= 1'b0; m_addr <= '0; m_wdata <= '0;
      m_rdata <= '0; m_ptr <= N - 1;
    end else if (m_t == 0) begin
      if (|bus.req) begin
        m_t     <= 1;
        m_w     <= m_pick;
        m_ptr   <= m_pick;
        m_we    <= bit_of(bus.we, m_pick);
        m_addr  <= field_of(bus.addr, m_pick);
        m_wdata <= field_of(bus.wdata, m_pick);
      end
    end else if (m_t <= LAT) begin
      if (m_t == LAT && !m_we) m_rdata <= bus.mem_rdata;
      m_t <= m_t + 1;
    end else begin
      m_t <= 0;
    end
  end

  function automatic logic [32:0] exp_vec();
    logic [N-1:0] oh;
    logic act, dn;
    oh  = N'(1) << m_w;
    act = (m_t >= 1 && m_t <= LAT);
    dn  = (m_t == LAT + 1);
    return {(act || dn) ? oh : N'(0), dn ? oh : N'(0), m_t != 0, act,
            act && m_we, m_addr, m_wdata, m_rdata};
  endfunction

  function automatic logic [32:0] obs_vec();
    return {bus.gnt, bus.done, bus.busy, bus.mem_en, bus.mem_we,
            bus.mem_addr, bus.mem_wdata, bus.rdata};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0; bus.mem_rdata = '0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    tick();
    tick();
    total++;
    if (obs_vec() !== 33'h0) $display("FAIL reset_outputs got %h exp %h", obs_vec(), 33'h0);
    else passed++;
    total++;
    if (obs_vec() !== exp_vec()) $display("FAIL reset_model got %h exp %h", obs_vec(), exp_vec());
    else passed++;
    reset = 1'b1;
  endtask

  task automatic test_single_read();
    bus.req = 3'b001; bus.we = 3'b000;
    bus.addr = {8'($urandom), 8'($urandom), 8'h10};
    bus.wdata = 24'($urandom);
    bus.mem_rdata = 8'h5A;
    for (int c = 1; c <= 4; c++) begin
      tick();
      total++;
      if (obs_vec() !== exp_vec()) $display("FAIL read_model c%0d got %h exp %h", c, obs_vec(), exp_vec());
      else passed++;
      if (c <= 2) begin
        total++;
        if (bus.gnt !== 3'b001 || bus.mem_en !== 1'b1 || bus.mem_addr !== 8'h10)
          $display("FAIL read_access c%0d got gnt=%b en=%b addr=%h exp 001 1 10", c, bus.gnt, bus.mem_en, bus.mem_addr);
        else passed++;
      end else if (c == 3) begin
        total++;
        if (bus.done !== 3'b001 || bus.rdata !== 8'h5A || bus.mem_en !== 1'b0)
          $display("FAIL read_done got done=%b rdata=%h en=%b exp 001 5a 0", bus.done, bus.rdata, bus.mem_en);
        else passed++;
        bus.req = '0;
      end else begin
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 3'b000)
          $display("FAIL read_idle got busy=%b done=%b exp 0 000", bus.busy, bus.done);
        else passed++;
      end
    end
  endtask

  task automatic test_single_write();
    bus.req = 3'b010; bus.we = 3'b010;
    bus.addr = {8'($urandom), 8'h20, 8'($urandom)};
    bus.wdata = {8'($urandom), 8'hC3, 8'($urandom)};
    bus.mem_rdata = 8'($urandom);
    for (int c = 1; c <= 3; c++) begin
      tick();
      total++;
      if (obs_vec() !== exp_vec()) $display("FAIL write_model c%0d got %h exp %h", c, obs_vec(), exp_vec());
      else passed++;
      if (c <= 2) begin
        total++;
        if (bus.mem_we !== 1'b1 || bus.mem_wdata !== 8'hC3 || bus.gnt !== 3'b010 || bus.mem_addr !== 8'h20)
          $display("FAIL write_access c%0d got we=%b wdata=%h gnt=%b exp 1 c3 010", c, bus.mem_we, bus.mem_wdata, bus.gnt);
        else passed++;
      end else begin
        total++;
        if (bus.done !== 3'b010 || bus.rdata !== 8'h5A || bus.mem_we !== 1'b0)
          $display("FAIL write_done got done=%b rdata=%h we=%b exp 010 5a 0", bus.done, bus.rdata, bus.mem_we);
        else passed++;
        bus.req = '0; bus.we = '0;
      end
    end
    tick();
  endtask

  task automatic test_contention();
    logic [N-1:0] exp_order [4];
    logic [N-1:0] got_order [4];
    int           got_cyc   [4];
    int           n_g;
    logic [N-1:0] prev;
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{3'b001, 3'b010, 3'b100, 3'b001};
`else
    exp_order = '{3'b001, 3'b001, 3'b001, 3'b001};
`endif
    pulse_reset();
    bus.req = 3'b111; bus.we = 3'b000;
    bus.addr = 24'($urandom); bus.wdata = 24'($urandom);
    n_g = 0; prev = '0;
    for (int c = 1; c <= 16; c++) begin
      bus.mem_rdata = 8'($urandom);
      tick();
      total++;
      if (obs_vec() !== exp_vec()) $display("FAIL contend_model c%0d got %h exp %h", c, obs_vec(), exp_vec());
      else passed++;
      if (bus.gnt != '0 && prev == '0 && n_g < 4) begin
        got_order[n_g] = bus.gnt;
        got_cyc[n_g]   = c;
        n_g++;
      end
      prev = bus.gnt;
    end
    bus.req = '0;
    total++;
    if (n_g != 4) $display("FAIL contend_count got %0d exp 4", n_g);
    else passed++;
    for (int i = 0; i < n_g; i++) begin
      total++;
      if (got_order[i] !== exp_order[i]) $display("FAIL contend_order g%0d got %b exp %b", i, got_order[i], exp_order[i]);
      else passed++;
      if (i > 0) begin
        total++;
        if (got_cyc[i] - got_cyc[i-1] != LAT + 2)
          $display("FAIL contend_spacing g%0d got %0d exp %0d", i, got_cyc[i] - got_cyc[i-1], LAT + 2);
        else passed++;
      end
    end
    tick();
  endtask

  task automatic test_drop_req();
    int done0;
    int c;
    pulse_reset();
    bus.req = 3'b011; bus.we = 3'b000;
    bus.addr = 24'($urandom); bus.wdata = 24'($urandom);
    bus.mem_rdata = 8'($urandom);
    done0 = 0;
    tick();
    total++;
    if (bus.gnt !== 3'b001) $display("FAIL drop_first_gnt got %b exp 001", bus.gnt);
    else passed++;
    bus.req = 3'b010;
    for (c = 2; c <= 4; c++) begin
      tick();
      total++;
      if (obs_vec() !== exp_vec()) $display("FAIL drop_model c%0d got %h exp %h", c, obs_vec(), exp_vec());
      else passed++;
      if (bus.done == 3'b001) done0++;
    end
    total++;
    if (done0 != 1) $display("FAIL drop_done_count got %0d exp 1", done0);
    else passed++;
    tick();
    total++;
    if (bus.gnt !== 3'b010) $display("FAIL drop_next_gnt got %b exp 010", bus.gnt);
    else passed++;
    c = 0;
    while (bus.done !== 3'b010 && c < 10) begin
      tick();
      c++;
    end
    total++;
    if (bus.done !== 3'b010) $display("FAIL drop_next_done got %b exp 010 (timeout)", bus.done);
    else passed++;
    bus.req = '0;
    tick();
  endtask

  task automatic test_reset_mid_access();
    bus.req = 3'b001; bus.we = 3'b001;
    bus.addr = 24'($urandom); bus.wdata = 24'($urandom);
    tick();
    total++;
    if (bus.mem_en !== 1'b1) $display("FAIL rstmid_pre got en=%b exp 1", bus.mem_en);
    else passed++;
    #2 reset = 1'b0;
    #1;
    total++;
    if (bus.gnt !== 3'b000 || bus.mem_en !== 1'b0 || bus.busy !== 1'b0 || bus.mem_we !== 1'b0)
      $display("FAIL rstmid_async got gnt=%b en=%b busy=%b we=%b exp 000 0 0 0", bus.gnt, bus.mem_en, bus.busy, bus.mem_we);
    else passed++;
    tick();
    total++;
    if (bus.done !== 3'b000) $display("FAIL rstmid_nodone got %b exp 000", bus.done);
    else passed++;
    reset = 1'b1;
    bus.we = 3'b000;
    bus.mem_rdata = 8'($urandom);
    for (int c = 1; c <= 3; c++) begin
      tick();
      total++;
      if (obs_vec() !== exp_vec()) $display("FAIL rstmid_model c%0d got %h exp %h", c, obs_vec(), exp_vec());
      else passed++;
    end
    total++;
    if (bus.done !== 3'b001) $display("FAIL rstmid_after got done=%b exp 001", bus.done);
    else passed++;
    bus.req = '0;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bus.req       = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom);
      bus.we        = 3'($urandom);
      bus.addr      = 24'($urandom);
      bus.wdata     = 24'($urandom);
      bus.mem_rdata = 8'($urandom);
      tick();
      total++;
      if (obs_vec() !== exp_vec()) $display("FAIL random_model c%0d got %h exp %h", c, obs_vec(), exp_vec());
      else passed++;
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_drop_req();
    test_reset_mid_access();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
